// File: rtl/cameralink_line_reader_if.sv
// Bundle between the tap FIFOs, the line reader and the downstream pixel pipeline.
// slave = line reader side, master = FIFO/pipeline (or bench) side.
interface cameralink_line_reader_if #(
    parameter int NUM_CH    = 2,
    parameter int PX_PER_CH = 2,
    parameter int PX_W      = 12,
    parameter int LW_W      = 16
);
    localparam int DW = NUM_CH * PX_PER_CH * PX_W;

    logic [DW-1:0]     ch_dout;
    logic [NUM_CH-1:0] ch_empty;
    logic [NUM_CH-1:0] ch_prog_full;
    logic [NUM_CH-1:0] ch_rd_en;
    logic [NUM_CH-1:0] ch_mask;
    logic [LW_W-1:0]   line_width;
    logic              frame_valid;
    logic              new_frame;
    logic [DW-1:0]     pixel_data;
    logic              pixel_vld;
    logic              sof;
    logic              sol;
    logic              eol;
    logic [LW_W-1:0]   line_cnt;
    logic              busy;
    logic              line_abort;

    modport slave (
        input  ch_dout, ch_empty, ch_prog_full, ch_mask, line_width, frame_valid, new_frame,
        output ch_rd_en, pixel_data, pixel_vld, sof, sol, eol, line_cnt, busy, line_abort
    );

    modport master (
        output ch_dout, ch_empty, ch_prog_full, ch_mask, line_width, frame_valid, new_frame,
        input  ch_rd_en, pixel_data, pixel_vld, sof, sol, eol, line_cnt, busy, line_abort
    );
endinterface

// File: rtl/cameralink_line_reader.sv
// Drains NUM_CH tap FIFOs in whole-line bursts into one multi-pixel stream with sof/sol/eol.
// Define CL_LINE_READER_WATCHDOG_EN to enable the mid-burst empty-stall watchdog (line_abort).
module cameralink_line_reader #(
    parameter int NUM_CH      = 2,
    parameter int PX_PER_CH   = 2,
    parameter int PX_W        = 12,
    parameter int LW_W        = 16,
    parameter int STALL_LIMIT = 255
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst,
    cameralink_line_reader_if.slave    bus
);
    localparam int CW   = PX_PER_CH * PX_W;
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

`ifdef CL_LINE_READER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [NUM_CH-1:0] r_mask;
    logic [LW_W-1:0]   r_pix_cnt;
    logic [LW_W-1:0]   r_line_cnt;
    logic [SC_W-1:0]   r_stall_cnt;
    logic              r_sof_armed;
    logic              r_first;
    logic              r_pixel_vld;
    logic              r_sof;
    logic              r_sol;
    logic              r_eol;
    logic              r_busy;
    logic              r_line_abort;

    logic [LW_W-1:0]   w_step;
    logic [LW_W:0]     w_sum;
    logic              w_all_pf;
    logic              w_all_ne;
    logic              w_any_empty;
    logic              w_start;
    logic              w_rd;
    logic              w_last;
    logic              w_stall_hit;

    // Masked-out channels count as "ready" so they never gate a read or a burst start.
    assign w_all_pf    = &(bus.ch_prog_full | ~r_mask);
    assign w_all_ne    = &(~bus.ch_empty | ~r_mask);
    assign w_any_empty = |(bus.ch_empty & r_mask);
    assign w_step      = LW_W'(PX_PER_CH * $countones(r_mask));

    assign w_start = (r_state == ST_WAIT) && !bus.new_frame &&
                     (w_all_pf || (!bus.frame_valid && w_all_ne));
    assign w_rd    = (r_state == ST_BURST) && !bus.new_frame && w_all_ne;
    // One extra bit so pix_cnt + step cannot wrap past a large line_width.
    assign w_sum   = {1'b0, r_pix_cnt} + {1'b0, w_step};
    assign w_last  = w_rd && (w_sum >= {1'b0, bus.line_width});

    assign w_stall_hit = WD_EN && (r_state == ST_BURST) && !bus.new_frame && !w_all_ne &&
                         (r_stall_cnt == SC_W'(STALL_LIMIT - 1));

    always_comb begin
        w_state_next = r_state;
        if (bus.new_frame) begin
            w_state_next = ST_WAIT;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_WAIT: begin
                    if (w_start)
                        w_state_next = ST_BURST;
                    else if (!bus.frame_valid && w_any_empty)
                        w_state_next = ST_IDLE;
                end
                ST_BURST: begin
                    if (w_last || w_stall_hit)
                        w_state_next = ST_WAIT;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state      <= ST_IDLE;
            r_mask       <= '1;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_sof_armed  <= 1'b0;
            r_first      <= 1'b0;
            r_pixel_vld  <= 1'b0;
            r_sof        <= 1'b0;
            r_sol        <= 1'b0;
            r_eol        <= 1'b0;
            r_busy       <= 1'b0;
            r_line_abort <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next == ST_BURST);
            r_pixel_vld <= w_rd;
            r_sof       <= w_rd && r_sof_armed;
            r_sol       <= w_rd && r_first;
            r_eol       <= w_last;

            if (bus.new_frame) begin
                r_mask       <= (bus.ch_mask == '0) ? NUM_CH'(1) : bus.ch_mask;
                r_pix_cnt    <= '0;
                r_line_cnt   <= '0;
                r_line_abort <= 1'b0;
                r_stall_cnt  <= '0;
                r_sof_armed  <= 1'b1;
                r_first      <= 1'b0;
            end else begin
                if (w_start) begin
                    r_pix_cnt <= '0;
                    r_first   <= 1'b1;
                end

                if (w_rd) begin
                    r_pix_cnt   <= w_sum[LW_W-1:0];
                    r_first     <= 1'b0;
                    r_sof_armed <= 1'b0;
                    r_stall_cnt <= '0;
                end else if (w_stall_hit) begin
                    r_stall_cnt  <= '0;
                    r_line_abort <= 1'b1;
                end else if (WD_EN && r_state == ST_BURST) begin
                    r_stall_cnt <= r_stall_cnt + SC_W'(1);
                end else begin
                    r_stall_cnt <= '0;
                end

                if (w_last)
                    r_line_cnt <= r_line_cnt + LW_W'(1);
            end
        end
    end

    assign bus.ch_rd_en   = w_rd ? r_mask : '0;
    assign bus.pixel_vld  = r_pixel_vld;
    assign bus.sof        = r_sof;
    assign bus.sol        = r_sol;
    assign bus.eol        = r_eol;
    assign bus.line_cnt   = r_line_cnt;
    assign bus.busy       = r_busy;
    assign bus.line_abort = WD_EN && r_line_abort;

    // Disabled taps are zeroed so stale FIFO contents never leak downstream.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_px_mask
            assign bus.pixel_data[gi*CW +: CW] = r_mask[gi] ? bus.ch_dout[gi*CW +: CW] : '0;
        end
    endgenerate
endmodule

// File: tb/tb_cameralink_line_reader.sv
// Directed bench for cameralink_line_reader: FIFO model, expected-beat queue and a decoupled monitor.
module tb_cameralink_line_reader;
    localparam int NUM_CH      = 2;
    localparam int PX_PER_CH   = 2;
    localparam int PX_W        = 12;
    localparam int LW_W        = 16;
    localparam int STALL_LIMIT = 8;
    localparam int CW          = PX_PER_CH * PX_W;
    localparam int DW          = NUM_CH * CW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          sol;
        logic          eol;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cameralink_line_reader_if #(
        .NUM_CH(NUM_CH), .PX_PER_CH(PX_PER_CH), .PX_W(PX_W), .LW_W(LW_W)
    ) bus ();

    cameralink_line_reader #(
        .NUM_CH(NUM_CH), .PX_PER_CH(PX_PER_CH), .PX_W(PX_W), .LW_W(LW_W),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .bus(bus)
    );

    beat_t          exp_q[$];
    logic [CW-1:0]  fq0[$];
    logic [CW-1:0]  fq1[$];
    logic [CW-1:0]  r_dout0, r_dout1;
    logic           fe0, fe1;
    logic           force0 = 1'b0;
    logic           force1 = 1'b0;
    logic [1:0]     exp_rd_mask = 2'b00;
    int             checks = 0;
    int             errors = 0;
    int             rd_cycles = 0;
    int             seq = 0;

    assign bus.ch_dout  = {r_dout1, r_dout0};
    assign bus.ch_empty = {fe1 | force1, fe0 | force0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Standard-mode FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rst) begin
            r_dout0 <= '0;
            r_dout1 <= '0;
            fe0     <= 1'b1;
            fe1     <= 1'b1;
        end else begin
            if (bus.ch_rd_en[0] && fq0.size() > 0) r_dout0 <= fq0.pop_front();
            if (bus.ch_rd_en[1] && fq1.size() > 0) r_dout1 <= fq1.pop_front();
            fe0 <= (fq0.size() == 0);
            fe1 <= (fq1.size() == 0);
        end
    end

    always @(negedge clk) begin
        beat_t e;
        #2;
        if (!rst) begin
            if (bus.ch_rd_en != 2'b00) begin
                rd_cycles++;
                check("rd_en_mask", 64'(bus.ch_rd_en), 64'(exp_rd_mask));
                check("rd_on_empty", 64'(bus.ch_rd_en & bus.ch_empty), 64'd0);
            end
            if (bus.pixel_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, no beat expected", bus.pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(bus.pixel_data), 64'(e.data));
                    check("beat_sof_sol_eol", {61'd0, bus.sof, bus.sol, bus.eol},
                          {61'd0, e.sof, e.sol, e.eol});
                end
            end
        end
    end

    task automatic load_line(input int nbeats, input logic [1:0] m, input bit sof_first,
                             input bit with_eol);
        logic [CW-1:0] w0, w1;
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            w0 = CW'(32'h00A000 + seq);
            w1 = CW'(32'h0B0000 + seq * 3);
            seq++;
            if (m[0]) fq0.push_back(w0);
            if (m[1]) fq1.push_back(w1);
            b.data = {w1 & {CW{m[1]}}, w0 & {CW{m[0]}}};
            b.sof  = sof_first && (i == 0);
            b.sol  = (i == 0);
            b.eol  = with_eol && (i == nbeats - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_frame(input logic [1:0] m, input int lw);
        bus.ch_mask     = m;
        bus.line_width  = LW_W'(lw);
        bus.frame_valid = 1'b1;
        bus.new_frame   = 1'b1;
        exp_rd_mask     = m;
        @(negedge clk);
        bus.new_frame   = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (bus.ch_rd_en == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        bus.ch_mask      = 2'b00;
        bus.line_width   = '0;
        bus.frame_valid  = 1'b0;
        bus.new_frame    = 1'b0;
        bus.ch_prog_full = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_markers", {60'd0, bus.pixel_vld, bus.sof, bus.sol, bus.eol}, 64'd0);
        check("rst_rd_en", 64'(bus.ch_rd_en), 64'd0);
        check("rst_line_cnt", 64'(bus.line_cnt), 64'd0);
        check("rst_busy_abort", {62'd0, bus.busy, bus.line_abort}, 64'd0);
        check("rst_pixel_data", 64'(bus.pixel_data), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full line, both taps, 16 px at 4 px/beat -> 4 beats.
        load_line(4, 2'b11, 1'b1, 1'b1);
        start_frame(2'b11, 16);
        base = rd_cycles;
        bus.ch_prog_full = 2'b11;
        wait_rd("t1_start");
        check("t1_busy", 64'(bus.busy), 64'd1);
        bus.ch_prog_full = 2'b00;
        wait_drain("t1_drain");
        check("t1_line_cnt", 64'(bus.line_cnt), 64'd1);
        check("t1_reads", 64'(rd_cycles - base), 64'd4);
        check("t1_busy_end", 64'(bus.busy), 64'd0);

        // Tap 0 only, 10 px at 2 px/beat -> 5 beats, upper slice zeroed.
        load_line(5, 2'b01, 1'b1, 1'b1);
        start_frame(2'b01, 10);
        base = rd_cycles;
        bus.ch_prog_full = 2'b01;
        wait_rd("t2_start");
        bus.ch_prog_full = 2'b00;
        wait_drain("t2_drain");
        check("t2_line_cnt", 64'(bus.line_cnt), 64'd1);
        check("t2_reads", 64'(rd_cycles - base), 64'd5);

        // 18 px at 4 px/beat rounds up to 5 beats.
        load_line(5, 2'b11, 1'b1, 1'b1);
        start_frame(2'b11, 18);
        base = rd_cycles;
        bus.ch_prog_full = 2'b11;
        wait_rd("t3_start");
        bus.ch_prog_full = 2'b00;
        wait_drain("t3_drain");
        check("t3_line_cnt", 64'(bus.line_cnt), 64'd1);
        check("t3_reads", 64'(rd_cycles - base), 64'd5);

        // Second line of the same frame: no sof, tap 1 empty for 3 cycles mid-burst.
        load_line(5, 2'b11, 1'b0, 1'b1);
        base = rd_cycles;
        bus.ch_prog_full = 2'b11;
        wait_rd("t4_start");
        bus.ch_prog_full = 2'b00;
        @(negedge clk);
        force1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_stall_rd_en", 64'(bus.ch_rd_en), 64'd0);
            check("t4_stall_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        force1 = 1'b0;
        wait_drain("t4_drain");
        check("t4_line_cnt", 64'(bus.line_cnt), 64'd2);
        check("t4_reads", 64'(rd_cycles - base), 64'd5);

        // Tail flush: 2 words per tap, no prog_full, frame_valid falls.
        load_line(2, 2'b11, 1'b1, 1'b1);
        start_frame(2'b11, 8);
        base = rd_cycles;
        repeat (5) @(negedge clk);
        check("t5_hold_while_fv", 64'(rd_cycles - base), 64'd0);
        bus.frame_valid = 1'b0;
        wait_rd("t5_start");
        wait_drain("t5_drain");
        check("t5_line_cnt", 64'(bus.line_cnt), 64'd1);
        check("t5_reads", 64'(rd_cycles - base), 64'd2);
        // Back in IDLE: fresh data with frame_valid low must not start a burst.
        fq0.push_back(24'h0DEAD0);
        fq1.push_back(24'h0DEAD1);
        base = rd_cycles;
        repeat (10) @(negedge clk);
        check("t5_idle_no_read", 64'(rd_cycles - base), 64'd0);
        fq0.delete();
        fq1.delete();
        repeat (2) @(negedge clk);

`ifdef CL_LINE_READER_WATCHDOG_EN
        // Tap 1 runs dry after 2 beats; 8 stall cycles abort the line.
        load_line(2, 2'b11, 1'b1, 1'b0);
        fq0.push_back(24'h0C0001);
        fq0.push_back(24'h0C0002);
        start_frame(2'b11, 16);
        bus.ch_prog_full = 2'b11;
        wait_rd("wd_start");
        bus.ch_prog_full = 2'b00;
        n = 0;
        while (!bus.line_abort && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wd_abort", 64'(bus.line_abort), 64'd1);
        check("wd_stall_cycles", 64'(n), 64'd10);
        check("wd_line_cnt", 64'(bus.line_cnt), 64'd0);
        check("wd_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        check("wd_no_eol_pending", 64'(exp_q.size()), 64'd0);
        start_frame(2'b11, 16);
        check("wd_abort_cleared", 64'(bus.line_abort), 64'd0);
        fq0.delete();
        fq1.delete();
        repeat (3) @(negedge clk);
`else
        check("abort_tied_low", 64'(bus.line_abort), 64'd0);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cameralink_line_reader.md
# cameralink_line_reader

Parametrised sys_clk-domain line reader for Camera Link receive paths. It drains NUM_CH per-tap pixel FIFOs in whole-line bursts and emits a merged multi-pixel stream with start-of-frame, start-of-line and end-of-line markers. A line burst starts on a FIFO fill threshold, or as an end-of-frame tail flush. It adds a per-frame channel mask, empty-stall handling and an optional stall watchdog. It sits between the receive-side async FIFOs and the DMA/pixel pipeline.

## Interface
Parameters:
- NUM_CH, 2: number of tap FIFOs (1..4)
- PX_PER_CH, 2: pixels per FIFO word
- PX_W, 12: bits per pixel
- LW_W, 16: width of line_width and counters
- STALL_LIMIT, 255: empty-stall cycles tolerated mid-burst (watchdog builds only)

Ports:
- sys_clk  in  1  single clock
- sys_rst  in  1  reset, asynchronous, active-high
- ch_dout  in  NUM_CH*PX_PER_CH*PX_W  FIFO read data, standard mode, valid 1 cycle after read; channel k at slice k
- ch_empty  in  NUM_CH  FIFO empty flags
- ch_prog_full  in  NUM_CH  FIFO programmable-full flags
- ch_rd_en  out  NUM_CH  read strobe; identical on all masked-in channels, 0 on the others
- ch_mask  in  NUM_CH  enabled channels, sampled at new_frame
- line_width  in  LW_W  pixels per line across all enabled channels
- frame_valid  in  1  synchronised frame-valid level
- new_frame  in  1  one-cycle pulse at frame start
- pixel_data  out  NUM_CH*PX_PER_CH*PX_W  ch_dout with masked-out slices forced to 0
- pixel_vld, sof, sol, eol  out  1  beat qualifiers
- line_cnt  out  LW_W  lines completed in the current frame
- busy  out  1  state is BURST
- line_abort  out  1  sticky watchdog error; cleared by new_frame

## Operation
- States: IDLE, WAIT, BURST.
- IDLE → WAIT on new_frame. new_frame in any state:
  - mask_q <= ch_mask; if ch_mask==0, mask_q <= 1.
  - pix_cnt, line_cnt and line_abort <= 0.
  - sof armed.
  - Next state is WAIT. If this aborts a burst, no eol is emitted for it.
- step = PX_PER_CH × popcount(mask_q), computed at LW_W bits.
- WAIT → BURST when either condition holds:
  - (a) all mask_q channels have ch_prog_full=1; or
  - (b) frame_valid=0 and all mask_q channels have ch_empty=0 (tail flush).
- On entry to BURST, pix_cnt <= 0.
- WAIT → IDLE when frame_valid=0 and any mask_q channel is empty.
- BURST read rule: rd = all mask_q channels non-empty.
  - rd=1: pix_cnt += step.
  - rd=0: stall cycle; no read, counters hold.
- Last beat: rd=1 and pix_cnt + step >= line_width, compared at LW_W+1 bits so nothing wraps.
  - That beat carries eol and increments line_cnt (wraps at 2^LW_W).
  - State returns to WAIT.
- A line_width that is not a multiple of step rounds up to whole beats. line_width < step (including 0) gives a one-beat line.
- Beat markers:
  - sol is on the first beat of each burst.
  - sof is on the first beat after new_frame, then disarms.
  - A one-beat line carries sol and eol together.
- pixel_data is combinational from ch_dout and mask_q.
- Reset values: all outputs 0; state IDLE; mask_q all ones.

## Timing
- ch_rd_en is combinational from state, empties and mask_q. It is never asserted on a masked-in empty FIFO.
- pixel_vld, sof, sol and eol are registered copies of the read-cycle flags. They rise 1 cycle after ch_rd_en, aligned with ch_dout.
- Back-to-back beats are issued every cycle while FIFOs are non-empty.
- The earliest next burst starts 1 cycle after the eol read cycle (WAIT evaluated once).
- new_frame and a read in the same cycle: new_frame wins. No read is issued in that cycle.
- busy is registered from state.
- Reset mid-burst clears everything immediately. No eol or pixel_vld follows.

## Configuration
- CL_LINE_READER_WATCHDOG_EN defined:
  - A stall counter counts consecutive rd=0 cycles in BURST and clears on each read.
  - When the counter reaches STALL_LIMIT: line_abort <= 1, the line is dropped without eol, line_cnt is unchanged, and state goes to WAIT.
- Undefined: BURST waits indefinitely; line_abort is tied to 0.

## Test plan
- NUM_CH=2, mask=11, line_width=16 (step 4), both prog_full, FIFOs preloaded → 4 consecutive ch_rd_en=11; pixel_vld 4 cycles; sof+sol on beat 1, eol on beat 4; line_cnt=1.
- mask=01, line_width=10 (step 2) → 5 beats, ch_rd_en=01, upper slice of pixel_data=0, eol on beat 5.
- line_width=18, step 4 → 5 beats (rounded up), eol on beat 5.
- ch_empty[1] pulses high for 3 cycles mid-burst → ch_rd_en=00 for those cycles; burst resumes; total beats unchanged.
- frame_valid falls with 2 words per FIFO and no prog_full → tail flush of 2 beats with sol and eol; then WAIT → IDLE.
- Watchdog build, STALL_LIMIT=8, FIFO 1 held empty mid-line → line_abort=1 after 8 stall cycles, no eol, line_cnt unchanged; new_frame clears line_abort.
